// File: rtl/edge_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : edge_pkg -- scan sequencer state encoding and window constants. Rev 1.0
//------------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_READ      = 3'd2,
    ST_CALC_REQ  = 3'd3,
    ST_CALC_WAIT = 3'd4,
    ST_WRITE     = 3'd5,
    ST_NEXT      = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  localparam int WIN_SIZE  = 3;
  localparam int WIN_TAPS  = WIN_SIZE * WIN_SIZE;
  localparam int WIN_IDX_W = 4;
  localparam int PIX_W     = 8;

endpackage
`default_nettype wire

// File: rtl/scan_counter_2d.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : scan_counter_2d -- raster x/y counter, x inner. Rev 1.0
//------------------------------------------------------------------------------
module scan_counter_2d
  import edge_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       inc_i,
  output logic [$clog2(IMG_W)-1:0]   x_o,
  output logic [$clog2(IMG_H)-1:0]   y_o,
  output logic                       last_o
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == XW'(IMG_W - 1));
  assign y_end = (y_q == YW'(IMG_H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_end && y_end;

endmodule
`default_nettype wire

// File: rtl/edge_scan_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : edge_scan_controller -- 3x3 window fetch / kernel / write-back
// sequencer. Define BORDER_COPY_EN to copy border pixels instead of zeroing. Rev 1.0
//------------------------------------------------------------------------------
module edge_scan_controller
  import edge_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     src_base_i,
  input  logic [ADDR_W-1:0]     dst_base_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     avm_address_o,
  output logic                  avm_read_o,
  output logic                  avm_write_o,
  output logic [PIX_W-1:0]      avm_writedata_o,
  input  logic [PIX_W-1:0]      avm_readdata_i,
  input  logic                  avm_waitrequest_i,
  output logic                  win_valid_o,
  output logic [WIN_IDX_W-1:0]  win_idx_o,
  output logic [PIX_W-1:0]      win_data_o,
  output logic                  calc_start_o,
  input  logic                  calc_done_i,
  input  logic [PIX_W-1:0]      calc_result_i
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_e                 state_q;
  logic                   busy_q, done_q, read_q, write_q, calc_start_q, border_rd_q;
  logic [ADDR_W-1:0]      addr_q, src_q, dst_q;
  logic [PIX_W-1:0]       wdata_q;
  logic [WIN_IDX_W-1:0]   idx_q;

  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   last, cnt_clear, cnt_inc, border;
  logic [ADDR_W-1:0]      pix_off, src_ctr, dst_pix;

  assign cnt_clear = (state_q == ST_IDLE) && start_i;
  assign cnt_inc   = (state_q == ST_NEXT) && !last;

  scan_counter_2d #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .x_o     (x),
    .y_o     (y),
    .last_o  (last)
  );

  assign border  = (x == '0) || (x == XW'(IMG_W - 1)) || (y == '0) || (y == YW'(IMG_H - 1));
  assign pix_off = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
  assign src_ctr = src_q + pix_off;
  assign dst_pix = dst_q + pix_off;

  // Tap address relative to the centre pixel; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] ctr,
                                                 input logic [WIN_IDX_W-1:0] idx);
    logic [ADDR_W-1:0] dy, dx;
    dy = ADDR_W'(idx / WIN_IDX_W'(WIN_SIZE));
    dx = ADDR_W'(idx % WIN_IDX_W'(WIN_SIZE));
    return ctr + dy * ADDR_W'(IMG_W) + dx - ADDR_W'(IMG_W + 1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      calc_start_q <= 1'b0;
      border_rd_q  <= 1'b0;
      addr_q       <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            src_q   <= src_base_i;
            dst_q   <= dst_base_i;
            busy_q  <= 1'b1;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          idx_q <= '0;
          if (border) begin
`ifdef BORDER_COPY_EN
            border_rd_q <= 1'b1;
            read_q      <= 1'b1;
            addr_q      <= src_ctr;
            state_q     <= ST_READ;
`else
            write_q     <= 1'b1;
            wdata_q     <= '0;
            addr_q      <= dst_pix;
            state_q     <= ST_WRITE;
`endif
          end else begin
            border_rd_q <= 1'b0;
            read_q      <= 1'b1;
            addr_q      <= tap_addr(src_ctr, '0);
            state_q     <= ST_READ;
          end
        end
        ST_READ: begin
          if (!avm_waitrequest_i) begin
            if (border_rd_q) begin
              border_rd_q <= 1'b0;
              read_q      <= 1'b0;
              wdata_q     <= avm_readdata_i;
              write_q     <= 1'b1;
              addr_q      <= dst_pix;
              state_q     <= ST_WRITE;
            end else if (idx_q == WIN_IDX_W'(WIN_TAPS - 1)) begin
              read_q       <= 1'b0;
              calc_start_q <= 1'b1;
              state_q      <= ST_CALC_REQ;
            end else begin
              idx_q  <= idx_q + WIN_IDX_W'(1);
              addr_q <= tap_addr(src_ctr, idx_q + WIN_IDX_W'(1));
            end
          end
        end
        ST_CALC_REQ: begin
          calc_start_q <= 1'b0;
          state_q      <= ST_CALC_WAIT;
        end
        ST_CALC_WAIT: begin
          if (calc_done_i) begin
            wdata_q <= calc_result_i;
            write_q <= 1'b1;
            addr_q  <= dst_pix;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest_i) begin
            write_q <= 1'b0;
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign avm_address_o   = addr_q;
  assign avm_read_o      = read_q;
  assign avm_write_o     = write_q;
  assign avm_writedata_o = wdata_q;
  assign calc_start_o    = calc_start_q;
  // Window strobe marks the accepting cycle of a kernel tap read only.
  assign win_valid_o     = (state_q == ST_READ) && read_q && !avm_waitrequest_i && !border_rd_q;
  assign win_idx_o       = idx_q;
  assign win_data_o      = win_valid_o ? avm_readdata_i : '0;

endmodule
`default_nettype wire

// File: doc/edge_scan_controller.md
# edge_scan_controller

Sequencer for the edge-detection filter. It walks every output pixel of an IMG_W×IMG_H 8-bit image in raster order. For each interior pixel it fetches the 3×3 neighbourhood over an Avalon-MM master, streams the nine samples into the kernel datapath, and writes the returned result to the destination buffer. Border pixels bypass the kernel. The block sits between the Avalon-MM memory fabric and the kernel datapath and is started by the CSR block.

## Interface

Parameters:
- IMG_W, 8: image width in pixels, ≥3.
- IMG_H, 8: image height in pixels, ≥3.
- ADDR_W, 16: Avalon byte-address width.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a frame; sampled only in IDLE.
- src_base_i  in  ADDR_W  source image base; latched at start.
- dst_base_i  in  ADDR_W  destination image base; latched at start.
- busy_o  out  1  high from the cycle after start is accepted until DONE.
- done_o  out  1  one-cycle pulse at frame end.
- avm_address_o  out  ADDR_W  Avalon byte address.
- avm_read_o  out  1  read request.
- avm_write_o  out  1  write request.
- avm_writedata_o  out  8  write data.
- avm_readdata_i  in  8  read data, valid when read is accepted (zero-latency slave).
- avm_waitrequest_i  in  1  slave stall.
- win_valid_o  out  1  window sample strobe.
- win_idx_o  out  4  sample index, dy*3+dx, 0..8.
- win_data_o  out  8  sample value.
- calc_start_o  out  1  one-cycle kernel start pulse.
- calc_done_i  in  1  kernel result valid.
- calc_result_i  in  8  kernel result.

## Operation

- States: IDLE, CHECK, READ, CALC_REQ, CALC_WAIT, WRITE, NEXT, DONE.
- IDLE: on start_i, latch both bases, clear x and y, then go to CHECK.
- CHECK: a pixel is border if x==0, x==IMG_W-1, y==0 or y==IMG_H-1. Border pixels go to WRITE with data 0. Interior pixels go to READ with window index 0.
- READ: issue 9 reads in order idx 0..8, dx inner. Address = src_base + (y+dy-1)*IMG_W + (x+dx-1).
  - Each accepted read (read_o=1 and waitrequest=0) pulses win_valid_o with idx and readdata in that same cycle.
  - After idx 8 is accepted, go to CALC_REQ.
- CALC_REQ: pulse calc_start_o for one cycle, then go to CALC_WAIT.
- CALC_WAIT: sample calc_done_i from the first cycle after the pulse. On done, register calc_result_i and go to WRITE.
- WRITE: write to dst_base + y*IMG_W + x. Hold until waitrequest=0, then go to NEXT.
- NEXT: x is the inner counter and wraps at IMG_W-1, at which point y increments. At x==IMG_W-1 and y==IMG_H-1, go to DONE. Otherwise go to CHECK.
- DONE: assert done_o for one cycle, deassert busy_o, return to IDLE.
- Arithmetic: address arithmetic is unsigned, modulo 2^ADDR_W, with no overflow flag. Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
- start_i while busy is ignored. calc_done_i outside CALC_WAIT is ignored.

## Timing

- Reset values: every output is 0 and the state is IDLE. Reset mid-frame drops read and write in the next cycle, with no completion of an outstanding transfer.
- Avalon: address, read, write and writedata stay stable while waitrequest is high. read and write are never asserted together.
- Cycle costs with zero waitrequest:
  - Border pixel: 3 cycles (CHECK, WRITE, NEXT).
  - Interior pixel: 14 cycles when calc_done_i arrives on the first CALC_WAIT cycle.
- done_o follows the final NEXT by exactly one cycle.
- Each waitrequest cycle adds exactly one cycle.

## Configuration

- BORDER_COPY_EN undefined: border pixels write 0 and issue no read.
- BORDER_COPY_EN defined: a border pixel first issues one read at src_base + y*IMG_W + x, then writes that value unchanged.
  - win_valid_o stays low for this read.
  - Border cost becomes 4 cycles.

## Structure

- Package edge_pkg holds:
  - state enum;
  - WIN_SIZE=3;
  - WIN_TAPS=9;
  - window index width;
  - pixel data width 8.
- Sub-module scan_counter_2d holds the x/y raster counter, with clear, inc, x, y, and last outputs, parameterised by IMG_W/IMG_H.
- The FSM, address generation and Avalon handling live in edge_scan_controller.

## Test plan

- 4×4 frame, src 0x100, dst 0x200, kernel returns the constant 0x5A with done one cycle after start:
  - 12 border writes of 0 and 4 writes of 0x5A at 0x205, 0x206, 0x209, 0x20A;
  - done_o at the expected cycle;
  - 36 reads total.
- Pixel (1,1) in the 4×4 frame: reads occur at 0x100, 0x101, 0x102, 0x104, 0x105, 0x106, 0x108, 0x109, 0x10A, and win_idx_o runs 0..8 matching readdata.
- Random 0–3 cycle waitrequest stalls: the address and data sequence equals the no-stall run, and signals stay stable during stalls.
- start_i pulsed mid-frame has no effect. rst_i asserted during READ gives all outputs 0 next cycle, and a fresh start then completes normally.
- With BORDER_COPY_EN defined: a 3×3 image with src bytes 0..8 produces destination bytes 0,1,2,3,K,5,6,7,8, where K is the kernel result.
- src 0xFFFC with ADDR_W=16 on a 3×3 image: addresses wrap to 0x0000..0x0004.
